// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, issue-reservation and source-check bus of regfile_wb_arbiter.
// The master side is driven by the execution units and the issue stage.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [AW-1:0]      wta;
  logic [DW-1:0]      wtd;
  logic               cnt;
  logic               iss_valid;
  logic [AW-1:0]      iss_addr;
  logic               iss_ready;
  logic [AW-1:0]      rsa;
  logic [AW-1:0]      rta;
  logic               rs_busy;
  logic               rt_busy;

  modport master (
    output req_valid, req_addr, req_data, iss_valid, iss_addr, rsa, rta,
    input  req_ready, wta, wtd, cnt, iss_ready, rs_busy, rt_busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, iss_valid, iss_addr, rsa, rta,
    output req_ready, wta, wtd, cnt, iss_ready, rs_busy, rt_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NREQ writeback requesters onto the register-file write port and tracks pending writes.
// Define WB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic clk,
  input  logic rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREG = 2**AW;

  logic [NREQ-1:0] grant;
  logic            xfer;
  logic [AW-1:0]   selAddr;
  logic [DW-1:0]   selData;

  logic            cnt_q, cnt_d;
  logic [AW-1:0]   wta_q, wta_d;
  logic [DW-1:0]   wtd_q, wtd_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            issReady;

`ifdef WB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    grant   = '0;
    selAddr = '0;
    selData = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        selAddr  = bus.req_addr[k*AW +: AW];
        selData  = bus.req_data[k*DW +: DW];
      end
    end
  end
`else
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr_q, ptr_d, gntIdx;

  // Scan offsets from farthest to nearest so the requester right after ptr wins.
  always_comb begin
    grant   = '0;
    gntIdx  = '0;
    selAddr = '0;
    selData = '0;
    for (int off = NREQ; off >= 1; off--) begin
      for (int k = 0; k < NREQ; k++) begin
        if (k == (int'(ptr_q) + off) % NREQ && bus.req_valid[k]) begin
          grant    = '0;
          grant[k] = 1'b1;
          gntIdx   = PW'(k);
          selAddr  = bus.req_addr[k*AW +: AW];
          selData  = bus.req_data[k*DW +: DW];
        end
      end
    end
  end

  assign ptr_d = xfer ? gntIdx : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PW'(NREQ - 1);
    else     ptr_q <= ptr_d;
  end
`endif

  assign xfer          = |grant;
  assign bus.req_ready = grant;

  // Writes to register 0 are accepted from the requester but never reach the register file.
  always_comb begin
    cnt_d = xfer && (selAddr != '0);
    wta_d = xfer ? selAddr : wta_q;
    wtd_d = xfer ? selData : wtd_q;
  end

  assign issReady = !busy_q[bus.iss_addr] || (bus.iss_addr == '0);

  // A new reservation overrides a same-cycle writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (cnt_q && wta_q != '0)
      busy_d[wta_q] = 1'b0;
    if (bus.iss_valid && issReady && bus.iss_addr != '0)
      busy_d[bus.iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 1'b0;
      wta_q  <= '0;
      wtd_q  <= '0;
      busy_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wta_q  <= wta_d;
      wtd_q  <= wtd_d;
      busy_q <= busy_d;
    end
  end

  // The register file forwards wtd while the write is on the port, so no stall then.
  assign bus.rs_busy   = busy_q[bus.rsa] && !(cnt_q && wta_q == bus.rsa);
  assign bus.rt_busy   = busy_q[bus.rta] && !(cnt_q && wta_q == bus.rta);
  assign bus.iss_ready = issReady;
  assign bus.cnt       = cnt_q;
  assign bus.wta       = wta_q;
  assign bus.wtd       = wtd_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expected register-file writes go through a queue
// that a negedge monitor drains, while grant/busy/ready values are checked in-line.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   g;
  wr_t  expQ[$];
  wr_t  monEntry;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus();

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Every write seen on the port must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (bus.cnt === 1'b1) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_write actual=wta %0d wtd %h required=no write", bus.wta, bus.wtd);
      end else begin
        monEntry = expQ.pop_front();
        if (monEntry.c != cyc || monEntry.a !== bus.wta || monEntry.d !== bus.wtd) begin
          bad++;
          $display("[TB] FAIL write_port actual=cyc %0d wta %0d wtd %h required=cyc %0d wta %0d wtd %h",
                   cyc, bus.wta, bus.wtd, monEntry.c, monEntry.a, monEntry.d);
        end
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [2:0] v,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                               input logic iv, input logic [AW-1:0] ia,
                               input logic [AW-1:0] s, input logic [AW-1:0] t);
    @(negedge clk);
    rst           = r;
    bus.req_valid = v;
    bus.req_addr  = {a2, a1, a0};
    bus.req_data  = {d2, d1, d0};
    bus.iss_valid = iv;
    bus.iss_addr  = ia;
    bus.rsa       = s;
    bus.rta       = t;
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] ia, input logic [AW-1:0] s, input logic [AW-1:0] t);
    applyStimulus(1'b0, 3'b000, '0, '0, '0, '0, '0, '0, 1'b0, ia, s, t);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expectWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.c = cyc + 1;
    e.a = a;
    e.d = d;
    expQ.push_back(e);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_addr  = '0;
    bus.rsa       = '0;
    bus.rta       = '0;
    @(posedge clk);

    $display("[TB] reset state");
    idle(5'd5, 5'd5, 5'd5);
    checkOutput("rst_cnt", 32'(bus.cnt), 32'd0);
    checkOutput("rst_wta", 32'(bus.wta), 32'd0);
    checkOutput("rst_wtd", bus.wtd, 32'd0);
    checkOutput("rst_rs_busy", 32'(bus.rs_busy), 32'd0);
    checkOutput("rst_rt_busy", 32'(bus.rt_busy), 32'd0);
    checkOutput("rst_iss_ready", 32'(bus.iss_ready), 32'd1);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);

    $display("[TB] single requester");
    applyStimulus(1'b0, 3'b001, 5'd5, '0, '0, 32'hA5, '0, '0, 1'b0, '0, '0, '0);
    checkOutput("t2_ready", 32'(bus.req_ready), 32'b001);
    expectWrite(5'd5, 32'hA5);
    idle('0, '0, '0);
    checkOutput("t2_cnt_on", 32'(bus.cnt), 32'd1);
    checkOutput("t2_wta", 32'(bus.wta), 32'd5);
    checkOutput("t2_wtd", bus.wtd, 32'hA5);
    idle('0, '0, '0);
    checkOutput("t2_cnt_off", 32'(bus.cnt), 32'd0);

    $display("[TB] all requesters valid");
    applyStimulus(1'b1, 3'b000, '0, '0, '0, '0, '0, '0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, '0, '0, '0);
`ifdef WB_FIXED_PRIO_EN
      g = 0;
`else
      g = i % 3;
`endif
      checkOutput($sformatf("t3_grant%0d", i), 32'(bus.req_ready), 32'd1 << g);
      expectWrite(AW'(g + 1), 32'h11 * DW'(g + 1));
    end

    $display("[TB] scoreboard reserve and clear");
    applyStimulus(1'b0, 3'b000, '0, '0, '0, '0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd7);
    checkOutput("t4_iss_ready_first", 32'(bus.iss_ready), 32'd1);
    checkOutput("t4_rs_busy_before", 32'(bus.rs_busy), 32'd0);
    applyStimulus(1'b0, 3'b000, '0, '0, '0, '0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd7);
    checkOutput("t4_iss_ready_second", 32'(bus.iss_ready), 32'd0);
    checkOutput("t4_rs_busy", 32'(bus.rs_busy), 32'd1);
    checkOutput("t4_rt_busy", 32'(bus.rt_busy), 32'd1);
    applyStimulus(1'b0, 3'b010, '0, 5'd7, '0, '0, 32'h77, '0, 1'b0, 5'd7, 5'd7, '0);
    checkOutput("t4_ready", 32'(bus.req_ready), 32'b010);
    checkOutput("t4_rs_busy_wait", 32'(bus.rs_busy), 32'd1);
    expectWrite(5'd7, 32'h77);
    idle(5'd7, 5'd7, '0);
    checkOutput("t4_rs_busy_fwd", 32'(bus.rs_busy), 32'd0);
    checkOutput("t4_iss_ready_fwd", 32'(bus.iss_ready), 32'd0);
    idle(5'd7, 5'd7, '0);
    checkOutput("t4_rs_busy_after", 32'(bus.rs_busy), 32'd0);
    checkOutput("t4_iss_ready_after", 32'(bus.iss_ready), 32'd1);

    $display("[TB] address zero");
    applyStimulus(1'b0, 3'b100, '0, '0, '0, '0, '0, 32'hFFFF, 1'b0, '0, '0, '0);
    checkOutput("t5_ready", 32'(bus.req_ready), 32'b100);
    applyStimulus(1'b0, 3'b000, '0, '0, '0, '0, '0, '0, 1'b1, '0, '0, '0);
    checkOutput("t5_cnt", 32'(bus.cnt), 32'd0);
    checkOutput("t5_iss_ready", 32'(bus.iss_ready), 32'd1);
    checkOutput("t5_rs_busy", 32'(bus.rs_busy), 32'd0);
    idle('0, '0, '0);
    checkOutput("t5_rs_busy_after", 32'(bus.rs_busy), 32'd0);
    checkOutput("t5_rt_busy_after", 32'(bus.rt_busy), 32'd0);

    $display("[TB] set wins and reset during write");
    applyStimulus(1'b0, 3'b001, 5'd9, '0, '0, 32'h99, '0, '0, 1'b0, '0, 5'd9, '0);
    checkOutput("t6_ready", 32'(bus.req_ready), 32'b001);
    checkOutput("t6_rs_busy_free", 32'(bus.rs_busy), 32'd0);
    expectWrite(5'd9, 32'h99);
    applyStimulus(1'b0, 3'b000, '0, '0, '0, '0, '0, '0, 1'b1, 5'd9, 5'd9, '0);
    checkOutput("t6_iss_ready", 32'(bus.iss_ready), 32'd1);
    idle(5'd9, 5'd9, '0);
    checkOutput("t6_set_wins", 32'(bus.rs_busy), 32'd1);
    checkOutput("t6_iss_blocked", 32'(bus.iss_ready), 32'd0);
    applyStimulus(1'b0, 3'b010, '0, 5'd3, '0, '0, 32'h33, '0, 1'b0, '0, 5'd9, '0);
    checkOutput("t6_ready_rr", 32'(bus.req_ready), 32'b010);
    expectWrite(5'd3, 32'h33);
    applyStimulus(1'b1, 3'b001, 5'd4, '0, '0, 32'h44, '0, '0, 1'b0, '0, 5'd9, '0);
    checkOutput("t6_cnt_inflight", 32'(bus.cnt), 32'd1);
    checkOutput("t6_rs_busy_pre", 32'(bus.rs_busy), 32'd1);
    idle(5'd9, 5'd9, '0);
    checkOutput("t6_cnt_reset", 32'(bus.cnt), 32'd0);
    checkOutput("t6_rs_busy_reset", 32'(bus.rs_busy), 32'd0);
    checkOutput("t6_iss_ready_reset", 32'(bus.iss_ready), 32'd1);
    idle('0, '0, '0);
    checkOutput("t6_cnt_dropped", 32'(bus.cnt), 32'd0);

    idle('0, '0, '0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
